shift_barrel_pipe: RTL and testbench

Parametrised, pipelined barrel shifter; successor to the single-mode combinational rotate-left shifter. Supports rotate left/right, logical left/right and arithmetic right, selected per transaction. Configurable register stages with a valid/retry handshake, so it can be placed in datapath pipelines where a single-cycle 64-bit log-shifter would miss timing.

---
 rtl/shift_barrel_pipe_if.sv | 38 +++
 rtl/shift_barrel_pipe.sv | 92 +++++++++
 tb/tb_shift_barrel_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_barrel_pipe_if.sv
// Operand/result handshake bundle for shift_barrel_pipe; slave is the shifter side.
// out_sticky exists only when SHIFT_BARREL_PIPE_STICKY_EN is defined.
interface shift_barrel_pipe_if #(
  parameter int Bits = 64
);
  localparam int L = $clog2(Bits);

  logic            inp_valid;
  logic            inp_retry;
  logic [Bits-1:0] inp_a;
  logic [L-1:0]    inp_sh;
  logic [2:0]      inp_op;
  logic            out_valid;
  logic            out_retry;
  logic [Bits-1:0] out_b;

`ifdef SHIFT_BARREL_PIPE_STICKY_EN
  logic            out_sticky;

  modport master (
    output inp_valid, inp_a, inp_sh, inp_op, out_retry,
    input  inp_retry, out_valid, out_b, out_sticky
  );
  modport slave (
    input  inp_valid, inp_a, inp_sh, inp_op, out_retry,
    output inp_retry, out_valid, out_b, out_sticky
  );
`else
  modport master (
    output inp_valid, inp_a, inp_sh, inp_op, out_retry,
    input  inp_retry, out_valid, out_b
  );
  modport slave (
    input  inp_valid, inp_a, inp_sh, inp_op, out_retry,
    output inp_retry, out_valid, out_b
  );
`endif
endinterface

// File: rtl/shift_barrel_pipe.sv
// Pipelined barrel shifter (ROL/ROR/SLL/SRL/SRA) with Stages register stages and a global stall.
// Define SHIFT_BARREL_PIPE_STICKY_EN to add out_sticky (OR of the bits shifted off the end).
module shift_barrel_pipe #(
  parameter int Bits   = 64,
  parameter int Stages = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  shift_barrel_pipe_if.slave  bus
);
  localparam int L = $clog2(Bits);
  localparam int G = (L + Stages - 1) / Stages;

  typedef struct packed {
    logic            vld;
    logic            rev;
    logic            rot;
    logic            fill;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    logic            sticky;
`endif
    logic [L-1:0]    sh;
    logic [Bits-1:0] data;
  } stage_t;

  stage_t q   [Stages];
  stage_t nxt [Stages];
  stage_t src0;
  logic   adv;

  function automatic logic [Bits-1:0] bit_rev(input logic [Bits-1:0] v);
    for (int i = 0; i < Bits; i++) bit_rev[i] = v[Bits-1-i];
  endfunction

  // Right ops run through the left-shift network on bit-reversed data; reserved ops shift by 0.
  always_comb begin
    src0      = '0;
    src0.vld  = bus.inp_valid;
    src0.data = bus.inp_a;
    src0.sh   = bus.inp_sh;
    case (bus.inp_op)
      3'b000: src0.rot = 1'b1;
      3'b001: begin src0.rot = 1'b1; src0.rev = 1'b1; end
      3'b010: src0.rev = 1'b0;
      3'b011: src0.rev = 1'b1;
      3'b100: begin src0.rev = 1'b1; src0.fill = bus.inp_a[Bits-1]; end
      default: src0.sh = '0;
    endcase
    if (src0.rev) src0.data = bit_rev(bus.inp_a);
  end

  always_comb begin
    stage_t cur;
    cur = src0;
    for (int s = 0; s < Stages; s++) begin
      for (int k = 0; k < L; k++) begin
        if ((k / G) == s && cur.sh[k]) begin
          if (cur.rot) begin
            cur.data = (cur.data << (1 << k)) | (cur.data >> (Bits - (1 << k)));
          end else begin
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
            cur.sticky = cur.sticky | (|(cur.data >> (Bits - (1 << k))));
`endif
            cur.data = (cur.data << (1 << k)) |
                       (cur.fill ? ~({Bits{1'b1}} << (1 << k)) : '0);
          end
        end
      end
      if (s == Stages - 1 && cur.rev) cur.data = bit_rev(cur.data);
      nxt[s] = cur;
      if (s < Stages - 1) cur = q[s];
    end
  end

  assign adv = !(q[Stages-1].vld && bus.out_retry);

  // Whole pipe advances together; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < Stages; s++) q[s] <= '0;
    end else if (adv) begin
      for (int s = 0; s < Stages; s++) q[s] <= nxt[s];
    end
  end

  assign bus.inp_retry  = !adv;
  assign bus.out_valid  = q[Stages-1].vld;
  assign bus.out_b      = q[Stages-1].data;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
  assign bus.out_sticky = q[Stages-1].sticky;
`endif
endmodule

// File: tb/tb_shift_barrel_pipe.sv
// Self-checking bench: directed 8-bit cases plus randomized 64-bit runs (Stages=1 and 6)
// scored against an arithmetic reference model.
module tb_shift_barrel_pipe;
  logic clk = 1'b0;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle = 0;
  bit   lat_check = 1'b1;

  logic [64:0]  exp_q [3][$];
  int           cyc_q [3][$];
  bit           accepted [3];
  bit           prev_hold [3];
  logic [63:0]  prev_b [3];
  int           acc_cnt [3];
  logic         st [3];

  logic [7:0] bb_a   [4] = '{8'h81, 8'h80, 8'h8F, 8'h8F};
  int         bb_sh  [4] = '{1, 3, 4, 4};
  logic [2:0] bb_op  [4] = '{3'd1, 3'd4, 3'd3, 3'd2};
  logic [7:0] bb_exp [4] = '{8'hC0, 8'hF0, 8'h08, 8'hF0};
  logic       bb_st  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] z_op   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

  shift_barrel_pipe_if #(.Bits(8))  bus8 ();
  shift_barrel_pipe_if #(.Bits(64)) bus_s1 ();
  shift_barrel_pipe_if #(.Bits(64)) bus_s6 ();

  shift_barrel_pipe #(.Bits(8),  .Stages(2)) dut8   (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));
  shift_barrel_pipe #(.Bits(64), .Stages(1)) dut_s1 (.clk(clk), .reset_n(reset_n), .bus(bus_s1.slave));
  shift_barrel_pipe #(.Bits(64), .Stages(6)) dut_s6 (.clk(clk), .reset_n(reset_n), .bus(bus_s6.slave));

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference: plain shift arithmetic on a width-masked value; returns {sticky, result}.
  function automatic logic [64:0] ref_model(int bits, logic [2:0] op, logic [63:0] a_in, int sh);
    logic [63:0] mask, a, v;
    logic        s;
    mask = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    a = a_in & mask;
    s = 1'b0;
    case (op)
      3'd0: v = ((a << sh) | (a >> (bits - sh))) & mask;
      3'd1: v = ((a >> sh) | (a << (bits - sh))) & mask;
      3'd2: begin v = (a << sh) & mask; s = (sh != 0) && ((a >> (bits - sh)) != 0); end
      3'd3: begin v = a >> sh; s = (a & ((64'd1 << sh) - 64'd1)) != 0; end
      3'd4: begin
        v = (a >> sh) | (a[bits-1] ? (mask & ~(mask >> sh)) : 64'd0);
        s = (a & ((64'd1 << sh) - 64'd1)) != 0;
      end
      default: v = a;
    endcase
    return {s, v};
  endfunction

  task automatic process(input int id, input int stages, input int bits,
                         input logic iv, input logic ir, input logic [63:0] a, input int sh,
                         input logic [2:0] op, input logic ov, input logic oretry,
                         input logic [63:0] ob, input logic ost);
    logic [64:0] e;
    int          c;
    accepted[id] = 1'b0;
    if (prev_hold[id]) begin
      check_output($sformatf("d%0d_hold_valid", id), 64'(ov), 64'd1);
      check_output($sformatf("d%0d_hold_b", id), ob, prev_b[id]);
    end
    prev_hold[id] = ov && oretry;
    prev_b[id]    = ob;
    if (ov && !oretry) begin
      if (exp_q[id].size() == 0) begin
        check_output($sformatf("d%0d_spurious", id), 64'(ov), 64'd0);
      end else begin
        e = exp_q[id].pop_front();
        c = cyc_q[id].pop_front();
        check_output($sformatf("d%0d_data", id), ob, e[63:0]);
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
        check_output($sformatf("d%0d_sticky", id), 64'(ost), 64'(e[64]));
`endif
        if (lat_check) check_output($sformatf("d%0d_latency", id), 64'(cycle - c), 64'(stages));
      end
    end
    if (iv && !ir) begin
      exp_q[id].push_back(ref_model(bits, op, a, sh));
      cyc_q[id].push_back(cycle);
      accepted[id] = 1'b1;
      acc_cnt[id]++;
    end
  endtask

  task automatic tick();
    #1;
    if (reset_n) begin
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
      st[0] = bus8.out_sticky; st[1] = bus_s1.out_sticky; st[2] = bus_s6.out_sticky;
`else
      st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
`endif
      process(0, 2, 8, bus8.inp_valid, bus8.inp_retry, 64'(bus8.inp_a), int'(bus8.inp_sh),
              bus8.inp_op, bus8.out_valid, bus8.out_retry, 64'(bus8.out_b), st[0]);
      process(1, 1, 64, bus_s1.inp_valid, bus_s1.inp_retry, bus_s1.inp_a, int'(bus_s1.inp_sh),
              bus_s1.inp_op, bus_s1.out_valid, bus_s1.out_retry, bus_s1.out_b, st[1]);
      process(2, 6, 64, bus_s6.inp_valid, bus_s6.inp_retry, bus_s6.inp_a, int'(bus_s6.inp_sh),
              bus_s6.inp_op, bus_s6.out_valid, bus_s6.out_retry, bus_s6.out_b, st[2]);
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic apply_stimulus(input bit v, input logic [7:0] a, input int sh, input logic [2:0] op);
    bus8.inp_valid = v;
    bus8.inp_a     = a;
    bus8.inp_sh    = 3'(sh);
    bus8.inp_op    = op;
  endtask

  task automatic idle_all();
    apply_stimulus(1'b0, 8'h00, 0, 3'd0);
    bus_s1.inp_valid = 1'b0; bus_s6.inp_valid = 1'b0;
    bus8.out_retry = 1'b0; bus_s1.out_retry = 1'b0; bus_s6.out_retry = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    idle_all();
    for (int i = 0; i < 10; i++) tick();
    for (int id = 0; id < 3; id++)
      check_output($sformatf("%s_empty_d%0d", tag, id), 64'(exp_q[id].size()), 64'd0);
  endtask

  task automatic random_cycle(input bit stall, input int t8, input int t64);
    if (!bus8.inp_valid || accepted[0]) begin
      bus8.inp_valid = (acc_cnt[0] < t8) && ($urandom_range(0, 3) != 0);
      bus8.inp_a = 8'($urandom); bus8.inp_sh = 3'($urandom_range(0, 7));
      bus8.inp_op = 3'($urandom_range(0, 7));
    end
    if (!bus_s1.inp_valid || accepted[1]) begin
      bus_s1.inp_valid = (acc_cnt[1] < t64) && ($urandom_range(0, 3) != 0);
      bus_s1.inp_a = {$urandom, $urandom}; bus_s1.inp_sh = 6'($urandom_range(0, 63));
      bus_s1.inp_op = 3'($urandom_range(0, 7));
    end
    if (!bus_s6.inp_valid || accepted[2]) begin
      bus_s6.inp_valid = (acc_cnt[2] < t64) && ($urandom_range(0, 3) != 0);
      bus_s6.inp_a = {$urandom, $urandom}; bus_s6.inp_sh = 6'($urandom_range(0, 63));
      bus_s6.inp_op = 3'($urandom_range(0, 7));
    end
    bus8.out_retry   = stall && ($urandom_range(0, 2) == 0);
    bus_s1.out_retry = stall && ($urandom_range(0, 2) == 0);
    bus_s6.out_retry = stall && ($urandom_range(0, 2) == 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_all();
    bus_s1.inp_a = '0; bus_s1.inp_sh = '0; bus_s1.inp_op = '0;
    bus_s6.inp_a = '0; bus_s6.inp_sh = '0; bus_s6.inp_op = '0;
    #12;
    check_output("rst_valid8", 64'(bus8.out_valid), 64'd0);
    check_output("rst_b8", 64'(bus8.out_b), 64'd0);
    check_output("rst_retry8", 64'(bus8.inp_retry), 64'd0);
    check_output("rst_valid64", 64'(bus_s6.out_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ROL: result must appear exactly two cycles after acceptance.
    apply_stimulus(1'b1, 8'h81, 1, 3'd0);
    tick();
    apply_stimulus(1'b0, 8'h00, 0, 3'd0);
    check_output("rol_early_valid", 64'(bus8.out_valid), 64'd0);
    tick();
    check_output("rol_valid", 64'(bus8.out_valid), 64'd1);
    check_output("rol_b", 64'(bus8.out_b), 64'h03);
    tick();

    for (int i = 0; i < 5; i++) begin
      if (i < 4) apply_stimulus(1'b1, bb_a[i], bb_sh[i], bb_op[i]);
      else apply_stimulus(1'b0, 8'h00, 0, 3'd0);
      tick();
      if (i >= 1) begin
        check_output($sformatf("b2b_valid%0d", i - 1), 64'(bus8.out_valid), 64'd1);
        check_output($sformatf("b2b_b%0d", i - 1), 64'(bus8.out_b), 64'(bb_exp[i-1]));
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
        check_output($sformatf("b2b_sticky%0d", i - 1), 64'(bus8.out_sticky), 64'(bb_st[i-1]));
`endif
      end
    end
    drain_and_check("b2b");

    // Fill the pipe behind a stalled output and keep it stalled for five cycles.
    lat_check = 1'b0;
    bus8.out_retry = 1'b1;
    apply_stimulus(1'b1, 8'h81, 1, 3'd0);
    tick();
    apply_stimulus(1'b1, 8'h3C, 2, 3'd3);
    tick();
    apply_stimulus(1'b1, 8'h5A, 3, 3'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("stall_inp_retry", 64'(bus8.inp_retry), 64'd1);
      check_output("stall_b", 64'(bus8.out_b), 64'h03);
      tick();
    end
    bus8.out_retry = 1'b0;
    tick();
    apply_stimulus(1'b0, 8'h00, 0, 3'd0);
    drain_and_check("stall");
    check_output("stall_count", 64'(acc_cnt[0]), 64'd8);
    lat_check = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (i < 6) apply_stimulus(1'b1, 8'hA5, 0, z_op[i]);
      else apply_stimulus(1'b0, 8'h00, 0, 3'd0);
      tick();
      if (i >= 1) check_output($sformatf("sh0_op%0d", z_op[i-1]), 64'(bus8.out_b), 64'hA5);
    end
    drain_and_check("sh0");

    // Reset with two transactions in flight: outputs clear at once, nothing emerges later.
    apply_stimulus(1'b1, 8'h11, 1, 3'd0);
    tick();
    apply_stimulus(1'b1, 8'h22, 2, 3'd2);
    tick();
    apply_stimulus(1'b0, 8'h00, 0, 3'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midrst_valid", 64'(bus8.out_valid), 64'd0);
    check_output("midrst_b", 64'(bus8.out_b), 64'd0);
    for (int id = 0; id < 3; id++) begin
      exp_q[id].delete(); cyc_q[id].delete(); prev_hold[id] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("postrst_valid", 64'(bus8.out_valid), 64'd0);
    end

    for (int id = 0; id < 3; id++) acc_cnt[id] = 0;
    for (int c = 0; c < 40000 && !(acc_cnt[0] >= 2000 && acc_cnt[1] >= 10000 && acc_cnt[2] >= 10000); c++)
      random_cycle(1'b0, 2000, 10000);
    check_output("rand_count8", 64'(acc_cnt[0]), 64'd2000);
    check_output("rand_count_s1", 64'(acc_cnt[1]), 64'd10000);
    check_output("rand_count_s6", 64'(acc_cnt[2]), 64'd10000);
    drain_and_check("rand");

    lat_check = 1'b0;
    for (int c = 0; c < 3000; c++) random_cycle(1'b1, 1 << 30, 1 << 30);
    drain_and_check("rstall");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
